// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_parser_pkg: shared constants for the UART command framer.
// Latency: n/a (constants and one pure function).
// Backpressure: n/a.
// Contents: default sync byte, opcodes, 3-bit FSM encodings, frame length,
// and the frame checksum helper.
package uart_cmd_parser_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [3:0] DEF_OP_WRITE  = 4'h1;
  localparam logic [3:0] DEF_OP_CONV   = 4'h2;

  // SYNC, CMD, DHI, DLO, CHK
  localparam int FRAME_LEN = 5;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S_CMD = 3'd1;
  localparam logic [2:0] S_DHI = 3'd2;
  localparam logic [2:0] S_DLO = 3'd3;
  localparam logic [2:0] S_CHK = 3'd4;

  // Checksum carried in the last byte of a frame.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return cmd ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// uart_timeout_timer: saturating 16-bit idle counter with an expire pulse.
// Latency: expire_o is combinational, high in the cycle whose edge would bring
//   the count to TIMEOUT_CYCLES-1. Backpressure: none.
// Ports: clk_i, reset_i (async, active-high); clr_i zeroes the count and
//   suppresses expiry; run_i enables counting; expire_o is the timeout pulse.
module uart_timeout_timer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd6380
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  logic [15:0] cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (run_i && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Fires once on the way to TIMEOUT_CYCLES-1; the count then moves past the
  // compare value (or saturates), so a caller that keeps run_i high sees no
  // second pulse. A clear in the same cycle always wins.
  assign expire_o = run_i && !clr_i && (cnt == (TIMEOUT_CYCLES - 16'd2));

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames UART bytes (SYNC CMD DHI DLO CHK) into register
//   writes / conversion starts. Latency: result pulses 1 cycle after CHK byte.
//   Backpressure: none; the receiver cannot stall, bytes are never refused.
// Ports: clk_i, reset_i (async, active-high); en_i; rx_data_i/rx_valid_i byte
//   strobe in; reg_we_o/reg_addr_o/reg_data_o write port; conv_start_o;
//   err_chk_o/err_cmd_o/err_timeout_o error pulses; busy_o frame in progress.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd6380,
  parameter logic [3:0]  OP_WRITE       = DEF_OP_WRITE,
  parameter logic [3:0]  OP_CONV        = DEF_OP_CONV
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        reg_we_o,
  output logic [3:0]  reg_addr_o,
  output logic [15:0] reg_data_o,
  output logic        conv_start_o,
  output logic        err_chk_o,
  output logic        err_cmd_o,
  output logic        err_timeout_o,
  output logic        busy_o
);

  logic [2:0] state;
  logic [7:0] cmd_q;
  logic [7:0] dhi_q;
  logic [7:0] dlo_q;
  logic       byte_acc;
  logic       tmo_expire;

  assign byte_acc = rx_valid_i && en_i;
  assign busy_o   = (state != IDLE);

  uart_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (byte_acc),
    .run_i   (busy_o),
    .expire_o(tmo_expire)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      cmd_q         <= '0;
      dhi_q         <= '0;
      dlo_q         <= '0;
      reg_we_o      <= 1'b0;
      reg_addr_o    <= '0;
      reg_data_o    <= '0;
      conv_start_o  <= 1'b0;
      err_chk_o     <= 1'b0;
      err_cmd_o     <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      // All result outputs are single-cycle pulses.
      reg_we_o      <= 1'b0;
      conv_start_o  <= 1'b0;
      err_chk_o     <= 1'b0;
      err_cmd_o     <= 1'b0;
      err_timeout_o <= 1'b0;

      if (!en_i) begin
        // Silent abort: no error pulse for a frame dropped by disable.
        state <= IDLE;
      end else if (rx_valid_i) begin
        // An accepted byte takes priority over a timeout due this cycle.
        case (state)
          IDLE: begin
            if (rx_data_i == SYNC_BYTE) state <= S_CMD;
          end
          S_CMD: begin
            cmd_q <= rx_data_i;
            state <= S_DHI;
          end
          S_DHI: begin
            dhi_q <= rx_data_i;
            state <= S_DLO;
          end
          S_DLO: begin
            dlo_q <= rx_data_i;
            state <= S_CHK;
          end
          S_CHK: begin
            state <= IDLE;
            if (rx_data_i != frame_chk(cmd_q, dhi_q, dlo_q)) begin
              err_chk_o <= 1'b1;
            end else if (cmd_q[7:4] == OP_WRITE) begin
              reg_we_o   <= 1'b1;
              reg_addr_o <= cmd_q[3:0];
              reg_data_o <= {dhi_q, dlo_q};
            end else if (cmd_q[7:4] == OP_CONV) begin
              conv_start_o <= 1'b1;
            end else begin
              err_cmd_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tmo_expire) begin
        // Partial frame discarded; latched bytes are overwritten next frame.
        state         <= IDLE;
        err_timeout_o <= 1'b1;
      end
    end
  end

endmodule
